// File: rtl/dac_frame_scheduler.sv
// ---------------------------------------------------------------------------
// dac_frame_scheduler
//
// Purpose:
//   Frames left/right DAC samples into a left-justified serial stream. For each
//   word it loads a downstream PISO shifter (shift_load), advances it once per
//   bit (shift_en), and produces the serial bit clock (bclk) and the word select
//   (lrclk). One frame is a left word followed by a right word, and each word is
//   WIDTH*BCLK_DIV clk cycles long, LOAD cycle included.
//
// Parameters:
//   WIDTH     bits per channel word (>= 2)
//   BCLK_DIV  clk cycles per serial bit (even, >= 2)
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous, active-high reset
//   enable      run request, sampled in IDLE and at the end of a right word
//   l_data      left sample
//   l_valid     left sample available
//   l_ready     left sample consumed this cycle
//   r_data      right sample
//   r_valid     right sample available
//   r_ready     right sample consumed this cycle
//   shift_data  word for the downstream shifter
//   shift_load  one-cycle pulse: shifter loads shift_data
//   shift_en    one-cycle pulse: shifter advances one bit
//   bclk        serial bit clock (registered)
//   lrclk       word select, 0 = left, 1 = right (registered)
//   underrun    one-cycle pulse: a word was loaded without a valid sample
//   busy        high in every state except IDLE
//
// Build option:
//   DAC_SCHED_UNDERRUN_REPEAT_EN  when defined, an underrun replays the last
//   sample transferred on that channel (0 if none since reset). When undefined,
//   an underrun loads all zeros and no replay registers exist.
//
// States:
//   state    | meaning
//   IDLE     | stopped, all outputs low, waiting for enable
//   LOAD_L   | one cycle: load left word, handshake left sample
//   SHIFT_L  | shifting out the rest of the left word
//   LOAD_R   | one cycle: load right word, handshake right sample
//   SHIFT_R  | shifting out the rest of the right word
// ---------------------------------------------------------------------------
module dac_frame_scheduler #(
  parameter int WIDTH    = 24,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] l_data,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [WIDTH-1:0] r_data,
  input  logic             r_valid,
  output logic             r_ready,
  output logic [WIDTH-1:0] shift_data,
  output logic             shift_load,
  output logic             shift_en,
  output logic             bclk,
  output logic             lrclk,
  output logic             underrun,
  output logic             busy
);

  // Counter widths; kept at least one bit so the minimum parameters still work.
  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_L  = 3'd1;
  localparam logic [2:0] S_SHIFT_L = 3'd2;
  localparam logic [2:0] S_LOAD_R  = 3'd3;
  localparam logic [2:0] S_SHIFT_R = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;

  logic             word_active;
  logic             bit_end;
  logic             word_end;
  logic             load_l;
  logic             load_r;
  logic             shifting;
  logic [WIDTH-1:0] fill_l;
  logic [WIDTH-1:0] fill_r;

  assign word_active = (state_q != S_IDLE);
  assign bit_end     = (div_cnt_q == DIV_LAST);
  assign word_end    = bit_end && (bit_idx_q == BIT_LAST);
  assign load_l      = (state_q == S_LOAD_L);
  assign load_r      = (state_q == S_LOAD_R);
  assign shifting    = (state_q == S_SHIFT_L) || (state_q == S_SHIFT_R);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_LOAD_L;
        end
      end
      S_LOAD_L: begin
        state_d = S_SHIFT_L;
      end
      S_SHIFT_L: begin
        // A left word is always followed by a right word, enable or not.
        if (word_end) begin
          state_d = S_LOAD_R;
        end
      end
      S_LOAD_R: begin
        state_d = S_SHIFT_R;
      end
      S_SHIFT_R: begin
        if (word_end) begin
          state_d = enable ? S_LOAD_L : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Bit timing. Both counters wrap to zero exactly at the end of a word, so
  // every LOAD cycle starts at div_cnt=0 / bit_idx=0 without a separate clear.
  // -------------------------------------------------------------------------
  always_comb begin
    div_cnt_d = '0;
    bit_idx_d = '0;
    if (word_active) begin
      if (bit_end) begin
        div_cnt_d = '0;
        bit_idx_d = (bit_idx_q == BIT_LAST) ? '0 : bit_idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
      end
    end
  end

  // bclk and lrclk are computed from next-cycle values so the flops line up
  // with div_cnt_q / state_q and the pins come straight off a register.
  always_comb begin
    bclk_d  = (state_d != S_IDLE) && (div_cnt_d >= DIV_HALF);
    lrclk_d = (state_d == S_LOAD_R) || (state_d == S_SHIFT_R);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_idx_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_idx_q <= bit_idx_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  // -------------------------------------------------------------------------
  // Underrun fill words
  // -------------------------------------------------------------------------
`ifdef DAC_SCHED_UNDERRUN_REPEAT_EN
  logic [WIDTH-1:0] last_l_q, last_l_d;
  logic [WIDTH-1:0] last_r_q, last_r_d;

  // Remember only samples that actually completed a handshake.
  always_comb begin
    last_l_d = (load_l && l_valid) ? l_data : last_l_q;
    last_r_d = (load_r && r_valid) ? r_data : last_r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else begin
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
    end
  end

  assign fill_l = last_l_q;
  assign fill_r = last_r_q;
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    shift_data = '0;
    if (load_l) begin
      shift_data = l_valid ? l_data : fill_l;
    end else if (load_r) begin
      shift_data = r_valid ? r_data : fill_r;
    end
  end

  // Ready is tied to the LOAD state of its own channel, so the two can never
  // be high together and never outside a LOAD cycle.
  assign l_ready    = load_l && l_valid;
  assign r_ready    = load_r && r_valid;
  assign shift_load = load_l || load_r;
  assign underrun   = (load_l && !l_valid) || (load_r && !r_valid);
  // The last bit of a word needs no advance: the next LOAD replaces the word.
  assign shift_en   = shifting && bit_end && (bit_idx_q != BIT_LAST);
  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign busy       = word_active;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
module tb_dac_frame_scheduler;

  localparam int W    = 8;
  localparam int DIV  = 4;
  localparam int WORD = W * DIV;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] l_data;
  logic         l_valid;
  logic         l_ready;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_ready;
  logic [W-1:0] shift_data;
  logic         shift_load;
  logic         shift_en;
  logic         bclk;
  logic         lrclk;
  logic         underrun;
  logic         busy;

  dac_frame_scheduler #(.WIDTH(W), .BCLK_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .l_data     (l_data),
    .l_valid    (l_valid),
    .l_ready    (l_ready),
    .r_data     (r_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .shift_data (shift_data),
    .shift_load (shift_load),
    .shift_en   (shift_en),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .underrun   (underrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         valid;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

`ifdef DAC_SCHED_UNDERRUN_REPEAT_EN
  localparam logic [W-1:0] R_FILL = 8'h3C;
`else
  localparam logic [W-1:0] R_FILL = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic v);
    exp_t e;
    e.data  = d;
    e.valid = v;
    sb.push_back(e);
  endtask

  // Reference timing model: off = cycles since the current word's LOAD,
  // ch = channel of the current word. Checked every falling edge.
  initial begin : monitor
    bit   m_known;
    bit   m_act;
    int   off;
    bit   ch;
    exp_t e;
    m_known = 0;
    m_act   = 0;
    off     = 0;
    ch      = 0;
    forever begin
      @(negedge clk);
      if (m_known) begin
        if (!m_act) begin
          check("idle_busy",       32'(busy), 0);
          check("idle_shift_load", 32'(shift_load), 0);
          check("idle_shift_en",   32'(shift_en), 0);
          check("idle_bclk",       32'(bclk), 0);
          check("idle_lrclk",      32'(lrclk), 0);
          check("idle_l_ready",    32'(l_ready), 0);
          check("idle_r_ready",    32'(r_ready), 0);
          check("idle_underrun",   32'(underrun), 0);
          check("idle_shift_data", 32'(shift_data), 0);
        end else begin
          check("busy",       32'(busy), 1);
          check("shift_load", 32'(shift_load), 32'(off == 0));
          check("shift_en",   32'(shift_en), 32'(((off % DIV) == DIV - 1) && (off < WORD - DIV)));
          check("bclk",       32'(bclk), 32'((off % DIV) >= DIV / 2));
          check("lrclk",      32'(lrclk), 32'(ch));
          if (off == 0) begin
            if (sb.size() == 0) begin
              check("sb_underflow", 32'(sb.size()), 1);
            end else begin
              e = sb.pop_front();
              check("load_data",     32'(shift_data), 32'(e.data));
              check("load_underrun", 32'(underrun), 32'(!e.valid));
              if (ch) begin
                check("load_r_ready", 32'(r_ready), 32'(e.valid));
                check("load_l_ready", 32'(l_ready), 0);
              end else begin
                check("load_l_ready", 32'(l_ready), 32'(e.valid));
                check("load_r_ready", 32'(r_ready), 0);
              end
            end
          end else begin
            check("shift_l_ready",  32'(l_ready), 0);
            check("shift_r_ready",  32'(r_ready), 0);
            check("shift_underrun", 32'(underrun), 0);
          end
        end
      end
      // Advance using inputs that the next rising edge will sample.
      if (rst) begin
        m_known = 1;
        m_act   = 0;
        off     = 0;
        ch      = 0;
      end else if (m_known) begin
        if (!m_act) begin
          if (enable) begin
            m_act = 1;
            off   = 0;
            ch    = 0;
          end
        end else if (off == WORD - 1) begin
          if (ch && !enable) begin
            m_act = 0;
          end else begin
            ch = !ch;
          end
          off = 0;
        end else begin
          off++;
        end
      end
    end
  end

  initial begin : stim
    rst     = 1'b1;
    enable  = 1'b0;
    l_data  = '0;
    r_data  = '0;
    l_valid = 1'b0;
    r_valid = 1'b0;
    repeat (3) step();

    @(negedge clk);
    check("rst_busy",       32'(busy), 0);
    check("rst_shift_data", 32'(shift_data), 0);
    check("rst_bclk",       32'(bclk), 0);

    // Three continuous frames; the second right load underruns.
    step();
    rst     = 1'b0;
    enable  = 1'b1;
    l_data  = 8'hA5;
    r_data  = 8'h3C;
    l_valid = 1'b1;
    r_valid = 1'b1;
    push(8'hA5, 1'b1);
    push(8'h3C, 1'b1);
    push(8'hA5, 1'b1);
    push(R_FILL, 1'b0);
    push(8'h5A, 1'b1);
    push(8'h3C, 1'b1);

    step();  // first LOAD_L cycle
    @(negedge clk);
    check("first_load",    32'(shift_load), 1);
    check("first_l_ready", 32'(l_ready), 1);
    check("first_data",    32'(shift_data), 32'h0A5);

    repeat (2 * WORD + WORD - 1) step();  // one cycle before the second LOAD_R
    r_valid = 1'b0;
    repeat (2) step();
    r_valid = 1'b1;
    l_data  = 8'h5A;

    // Drop enable during bit 4 of the third left word.
    repeat (4 * WORD + 4 * DIV + 1 - (3 * WORD + 1)) step();
    enable = 1'b0;
    repeat (6 * WORD - (4 * WORD + 4 * DIV + 1)) step();
    @(negedge clk);
    check("stop_busy",  32'(busy), 0);
    check("stop_lrclk", 32'(lrclk), 0);

    // Reset in the middle of a right word, then restart.
    step();
    enable = 1'b1;
    l_data = 8'hC3;
    r_data = 8'h81;
    push(8'hC3, 1'b1);
    push(8'h81, 1'b1);
    step();  // LOAD_L
    repeat (WORD + 10) step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    l_valid = 1'b0;
    push(8'h00, 1'b0);  // replay storage was cleared by reset
    push(8'h81, 1'b1);
    @(negedge clk);
    check("abort_busy",       32'(busy), 0);
    check("abort_shift_data", 32'(shift_data), 0);
    check("abort_lrclk",      32'(lrclk), 0);

    step();  // LOAD_L after restart
    @(negedge clk);
    check("restart_load",     32'(shift_load), 1);
    check("restart_lrclk",    32'(lrclk), 0);
    check("restart_underrun", 32'(underrun), 1);
    l_valid = 1'b1;
    enable  = 1'b0;
    repeat (2 * WORD + 3) step();

    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    check("end_busy",   32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_frame_scheduler.md
DAC_FRAME_SCHEDULER -- requirements
Module: dac_frame_scheduler

Interface
REQ-001 Parameter WIDTH, default 24: bits per channel word, >= 2.
REQ-002 Parameter BCLK_DIV, default 4: clk cycles per serial bit, even, >= 2.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  run request; sampled only in IDLE and at end of a right word.
REQ-006 l_data  input  WIDTH  left sample.
REQ-007 l_valid  input  1  left sample available.
REQ-008 l_ready  output  1  left sample consumed this cycle.
REQ-009 r_data, r_valid, r_ready  same widths and meaning as the left set, for the right channel.
REQ-010 shift_data  output  WIDTH  word to load into the downstream PISO shifter.
REQ-011 shift_load  output  1  one-cycle pulse: shifter loads shift_data.
REQ-012 shift_en  output  1  one-cycle pulse: shifter advances one bit.
REQ-013 bclk  output  1  serial bit clock.
REQ-014 lrclk  output  1  word select: 0 = left word, 1 = right word.
REQ-015 underrun  output  1  one-cycle pulse: a word was loaded without a valid sample.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, LOAD_L, SHIFT_L, LOAD_R, SHIFT_R; LOAD_x lasts exactly one cycle.
REQ-018 IDLE -> LOAD_L when enable=1; otherwise stay in IDLE.
REQ-019 LOAD_x: shift_load=1; x_ready=1 iff x_valid=1; shift_data=x_data if x_valid, else the underrun word (REQ-033/034); state then goes to SHIFT_x.
REQ-020 Handshake: a sample is transferred only when x_valid and x_ready are both high in the same cycle; ready is never high outside LOAD_x; ready is never high for both channels in one cycle.
REQ-021 Bit counter div_cnt counts 0..BCLK_DIV-1, restarts at 0 in each LOAD cycle, and wraps at every bit boundary.
REQ-022 Bit index counts 0..WIDTH-1 per word; a word lasts exactly WIDTH*BCLK_DIV cycles including its LOAD cycle.
REQ-023 shift_en=1 at div_cnt=BCLK_DIV-1 for bit indices 0..WIDTH-2 only; no shift_en on the last bit or in LOAD cycles.
REQ-024 bclk=0 while div_cnt < BCLK_DIV/2 and 1 otherwise; bclk is registered and glitch-free.
REQ-025 lrclk is 0 from LOAD_L through SHIFT_L and 1 from LOAD_R through SHIFT_R; it changes only in the LOAD cycle (left-justified, no one-bit delay).
REQ-026 After the last bit of SHIFT_L the state goes to LOAD_R.
REQ-027 After the last bit of SHIFT_R: with enable=1 the state goes to LOAD_L with no gap cycle; with enable=0 it goes to IDLE.
REQ-028 Deasserting enable mid-frame has no effect until the right word completes; a left word is always followed by a right word.
REQ-029 Once started, the frame period is exactly 2*WIDTH*BCLK_DIV cycles regardless of valid inputs.
REQ-030 underrun pulses in the LOAD_x cycle in which x_valid=0; it is never sticky.
REQ-031 In IDLE: bclk=0, lrclk=0, shift_en=0, shift_load=0, both ready outputs 0.

Reset
REQ-032 While rst=1: the state is IDLE; all counters are 0; all outputs are 0, including shift_data, bclk, lrclk, underrun and busy; the stored replay samples are 0. Reset asserted mid-word aborts the word in the next cycle, and the block restarts only from IDLE.

Configuration
REQ-033 Macro DAC_SCHED_UNDERRUN_REPEAT_EN defined: the underrun word is the last sample transferred on that channel, or 0 if no sample has been transferred since reset.
REQ-034 Macro DAC_SCHED_UNDERRUN_REPEAT_EN undefined: the underrun word is all zeros, and the replay registers are not built.

Verification (WIDTH=8, BCLK_DIV=4)
REQ-035 Reset, then enable=1 with l_valid=r_valid=1 and l_data=8'hA5, r_data=8'h3C -> LOAD_L on the cycle after enable; shift_data=8'hA5 with l_ready=1; 7 shift_en pulses spaced 4 cycles apart; LOAD_R 32 cycles after LOAD_L with shift_data=8'h3C.
REQ-036 Continuous enable for 3 frames -> shift_load pulses every 32 cycles; lrclk toggles every 32 cycles; bclk has period 4 with 50% duty.
REQ-037 r_valid=0 during the second LOAD_R -> underrun pulses once, r_ready=0, and shift_data=8'h3C with the macro defined or 8'h00 without it; frame timing is unchanged.
REQ-038 enable dropped during the 5th bit of SHIFT_L -> the right word still completes, then the state returns to IDLE with busy=0 and all outputs 0.
REQ-039 rst=1 for one cycle in the middle of SHIFT_R -> all outputs are 0 on the next cycle; after rst=0 with enable=1 the next LOAD is LOAD_L with lrclk=0.
